// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the write-back stage: exception codes, memory op kinds
// and sizes, plus the WB occupancy state.
package wb_ctrl_pkg;

    typedef enum logic [3:0] {
        EXC_NONE,
        EXC_INT,
        EXC_ADEF,
        EXC_ALE,
        EXC_SYS,
        EXC_BRK,
        EXC_INE,
        EXC_PIL,
        EXC_PIS,
        EXC_PIF,
        EXC_PME,
        EXC_PPI,
        EXC_TLBR,
        EXC_ADEM
    } exception_t;

    typedef enum logic [1:0] {
        MEM_NOP,
        MEM_LOAD,
        MEM_LOADU,
        MEM_STORE
    } mem_type_t;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD
    } mem_size_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WAIT,
        WB_DONE
    } wb_state_t;

    function automatic logic is_load(input mem_type_t t);
        return (t == MEM_LOAD) || (t == MEM_LOADU);
    endfunction

endpackage

// File: rtl/wb_ctrl_load_align.sv
// Extracts the addressed byte/half from a load response word and extends it
// to 32 bits (sign or zero).
module load_align
    import wb_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[7:0];
        case (addr_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            2'd3: byte_v = rdata_i[31:24];
            default: byte_v = rdata_i[7:0];
        endcase
        half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            MEM_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            MEM_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            default:  data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back stage: holds one instruction, waits for its memory response,
// drops responses belonging to flushed requests, and drives the RF write port.
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int unsigned DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_ready,
    input  logic        mem_req_fire,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_result,
    input  logic        mem_have_exception,
    input  exception_t  mem_exception_type,
    input  logic [4:0]  mem_dest,
    input  mem_type_t   mem_mem_type,
    input  mem_size_t   mem_mem_size,
    output logic        wb_allowin,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        wb_forwardable,
    output logic [31:0] wb_fwd_data,
    output logic        wb_have_exception,
    output exception_t  wb_exception_type,
    output logic [31:0] wb_badv
);

    localparam int unsigned DISCARD_MAX = (2 ** DISCARD_W) - 1;
    localparam int unsigned SUM_W       = DISCARD_W + 2;

    wb_state_t state_q, state_d;
    logic [DISCARD_W-1:0] discard_q, discard_d;

    logic [31:0] pc_q;
    logic        have_exc_q;
    exception_t  exc_type_q;
    logic [31:0] result_q;
    logic [4:0]  dest_q;
    mem_type_t   mem_type_q;
    mem_size_t   mem_size_q;

    logic             stage_valid;
    logic             stage_wait;
    logic             resp_live;
    logic             consume;
    logic             wb_ready;
    logic             load_fire;
    logic [1:0]       discard_inc;
    logic             discard_dec;
    logic [SUM_W-1:0] discard_sum;
    logic [31:0]      load_data;

    assign stage_valid = (state_q != WB_IDLE);
    assign stage_wait  = (state_q == WB_WAIT);
    // A response only belongs to the current instruction once every stale one is drained.
    assign resp_live   = data_ok && (discard_q == '0);
    assign consume     = stage_wait && resp_live;
    assign wb_ready    = stage_valid && (!stage_wait || resp_live);
    assign wb_allowin  = !stage_valid || wb_ready;
    assign load_fire   = mem_valid && mem_ready && wb_allowin && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WB_IDLE;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = WB_IDLE;
        end else if (load_fire) begin
            state_d = ((mem_mem_type != MEM_NOP) && !mem_have_exception) ? WB_WAIT : WB_DONE;
        end else if (wb_ready) begin
            state_d = WB_IDLE;
        end
    end

    always_comb begin
        discard_inc = 2'd0;
        if (flush) begin
            discard_inc = 2'(stage_wait && !resp_live) + 2'(mem_req_fire);
        end
        discard_dec = data_ok && (discard_q != '0);
        discard_sum = SUM_W'(discard_q) + SUM_W'(discard_inc) - SUM_W'(discard_dec);
        if (discard_sum > SUM_W'(DISCARD_MAX)) begin
            discard_d = '1;
        end else begin
            discard_d = discard_sum[DISCARD_W-1:0];
        end
    end

    assert property (@(posedge clk) disable iff (!reset) discard_sum <= SUM_W'(DISCARD_MAX));

    always_ff @(posedge clk) begin
        if (load_fire) begin
            pc_q       <= mem_pc;
            have_exc_q <= mem_have_exception;
            exc_type_q <= mem_exception_type;
            result_q   <= mem_result;
            dest_q     <= mem_dest;
            mem_type_q <= mem_mem_type;
            mem_size_q <= mem_mem_size;
        end
    end

    load_align u_load_align (
        .rdata_i    (rdata),
        .addr_i     (result_q[1:0]),
        .size_i     (mem_size_q),
        .unsigned_i (mem_type_q == MEM_LOADU),
        .data_o     (load_data)
    );

    assign rf_we    = wb_ready && !have_exc_q && (dest_q != 5'd0) && (mem_type_q != MEM_STORE);
    assign rf_waddr = dest_q;
    assign rf_wdata = is_load(mem_type_q) ? load_data : result_q;

    assign wb_valid          = wb_ready;
    assign wb_pc             = pc_q;
    assign wb_have_exception = wb_ready && have_exc_q;
    assign wb_exception_type = exc_type_q;
    assign wb_badv           = result_q;

    assign wb_forwardable = stage_valid && !have_exc_q && ((mem_type_q == MEM_NOP) || consume);
    assign wb_fwd_data    = rf_wdata;

endmodule

// File: tb/tb_wb_ctrl.sv
// Randomised scoreboard bench for wb_ctrl against a transaction-level model of
// the WB slot and the in-order memory response stream.
module tb_wb_ctrl;
    import wb_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, mem_valid, mem_ready, mem_req_fire;
    logic [31:0] mem_pc, mem_result;
    logic        mem_have_exception;
    exception_t  mem_exception_type;
    logic [4:0]  mem_dest;
    mem_type_t   mem_mem_type;
    mem_size_t   mem_mem_size;
    logic        wb_allowin;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_forwardable;
    logic [31:0] wb_fwd_data;
    logic        wb_have_exception;
    exception_t  wb_exception_type;
    logic [31:0] wb_badv;

    always #5 clk = ~clk;

    wb_ctrl #(.DISCARD_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_req_fire(mem_req_fire),
        .mem_pc(mem_pc), .mem_result(mem_result),
        .mem_have_exception(mem_have_exception), .mem_exception_type(mem_exception_type),
        .mem_dest(mem_dest), .mem_mem_type(mem_mem_type), .mem_mem_size(mem_mem_size),
        .wb_allowin(wb_allowin), .data_ok(data_ok), .rdata(rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_forwardable(wb_forwardable), .wb_fwd_data(wb_fwd_data),
        .wb_have_exception(wb_have_exception), .wb_exception_type(wb_exception_type),
        .wb_badv(wb_badv)
    );

    typedef struct {
        logic [31:0] pc;
        logic        exc;
        exception_t  etype;
        logic [31:0] result;
        logic [4:0]  dest;
        mem_type_t   mt;
        mem_size_t   ms;
        logic [31:0] rdata;
    } instr_t;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exc;
        exception_t  etype;
        logic [31:0] badv;
    } exp_t;

    typedef struct {
        bit          stale;
        logic [31:0] rdata;
    } resp_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  sb[$];
    resp_t outq[$];
    bit    slot_v;
    bit    slot_wait;
    exp_t  slot_rec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] expect_load(input logic [31:0] rd, input logic [31:0] addr,
                                                input mem_size_t sz, input bit uns);
        logic [31:0] v;
        if (sz == MEM_BYTE) begin
            v = (rd >> (8 * addr[1:0])) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == MEM_HALF) begin
            v = (rd >> (16 * addr[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic exp_t make_exp(input instr_t in);
        exp_t e;
        e.pc    = in.pc;
        e.exc   = in.exc;
        e.etype = in.etype;
        e.badv  = in.result;
        e.waddr = in.dest;
        e.we    = !in.exc && (in.dest != 5'd0) && (in.mt != MEM_STORE);
        if (in.mt == MEM_LOAD || in.mt == MEM_LOADU)
            e.wdata = expect_load(in.rdata, in.result, in.ms, in.mt == MEM_LOADU);
        else
            e.wdata = in.result;
        return e;
    endfunction

    function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] d,
                                  input mem_type_t mt, input mem_size_t ms, input logic [31:0] rd,
                                  input bit exc, input exception_t et);
        instr_t i;
        i.pc = pc; i.result = res; i.dest = d; i.mt = mt; i.ms = ms; i.rdata = rd;
        i.exc = exc; i.etype = et;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.pc     = $urandom & 32'hFFFF_FFFC;
        i.result = $urandom;
        i.dest   = 5'($urandom_range(0, 31));
        i.mt     = mem_type_t'(2'($urandom_range(0, 3)));
        i.ms     = mem_size_t'(2'($urandom_range(0, 2)));
        i.rdata  = $urandom;
        i.exc    = ($urandom_range(0, 9) == 0);
        i.etype  = i.exc ? exception_t'(4'($urandom_range(1, 13))) : EXC_NONE;
        return i;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (outq[k]) if (outq[k].stale) n++;
        return n;
    endfunction

    // One clock cycle: drive inputs, advance the model, check allowin mid-cycle.
    task automatic step(input bit fl, input bit dok, input bit mv, input bit mr,
                        input bit stale_fire, input instr_t in, output bit accepted);
        bit          live_resp;
        bit          ret;
        bit          allow_exp;
        bit          mrf;
        bit          is_mem;
        logic [31:0] rdv;
        resp_t       r;
        live_resp = 1'b0;
        rdv       = $urandom;
        if (dok && outq.size() > 0) begin
            r         = outq.pop_front();
            rdv       = r.rdata;
            live_resp = !r.stale;
        end
        ret = slot_v && (!slot_wait || live_resp);
        if (ret) sb.push_back(slot_rec);
        allow_exp = !slot_v || ret;
        accepted  = mv && mr && allow_exp && !fl;
        is_mem    = (in.mt != MEM_NOP) && !in.exc;
        mrf       = fl ? stale_fire : (accepted && is_mem);
        if (fl) begin
            slot_v = 1'b0;
            foreach (outq[k]) outq[k].stale = 1'b1;
            if (mrf) begin
                r.stale = 1'b1;
                r.rdata = $urandom;
                outq.push_back(r);
            end
        end else if (accepted) begin
            slot_v    = 1'b1;
            slot_rec  = make_exp(in);
            slot_wait = is_mem;
            if (is_mem) begin
                r.stale = 1'b0;
                r.rdata = in.rdata;
                outq.push_back(r);
            end
        end else if (ret) begin
            slot_v = 1'b0;
        end
        flush = fl; data_ok = dok; rdata = rdv;
        mem_valid = mv; mem_ready = mr; mem_req_fire = mrf;
        mem_pc = in.pc; mem_result = in.result; mem_dest = in.dest;
        mem_have_exception = in.exc; mem_exception_type = in.etype;
        mem_mem_type = in.mt; mem_mem_size = in.ms;
        @(negedge clk);
        chk("wb_allowin", 32'(wb_allowin), 32'(allow_exp));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_retire actual_pc=%h required=none at %0t", wb_pc, $time);
            end else begin
                e = sb.pop_front();
                chk("wb_pc", wb_pc, e.pc);
                chk("rf_we", 32'(rf_we), 32'(e.we));
                chk("wb_have_exception", 32'(wb_have_exception), 32'(e.exc));
                chk("wb_badv", wb_badv, e.badv);
                chk("wb_forwardable", 32'(wb_forwardable), 32'(!e.exc));
                if (e.we) begin
                    chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                    chk("rf_wdata", rf_wdata, e.wdata);
                    chk("wb_fwd_data", wb_fwd_data, e.wdata);
                end
                if (e.exc) chk("wb_exception_type", 32'(wb_exception_type), 32'(e.etype));
            end
        end else begin
            chk("idle_quiet", {29'd0, rf_we, wb_forwardable, wb_have_exception}, 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_have_exception"}, 32'(wb_have_exception), 32'd0);
        chk({tag, "_wb_allowin"}, 32'(wb_allowin), 32'd1);
    endtask

    instr_t nop_i;
    instr_t cur;
    bit     have_cur;
    bit     acc;

    initial begin
        nop_i = mk(32'h0, 32'h0, 5'd0, MEM_NOP, MEM_WORD, 32'h0, 1'b0, EXC_NONE);
        reset = 1'b0;
        flush = 1'b0; data_ok = 1'b0; rdata = '0;
        mem_valid = 1'b0; mem_ready = 1'b0; mem_req_fire = 1'b0;
        mem_pc = '0; mem_result = '0; mem_dest = '0;
        mem_have_exception = 1'b0; mem_exception_type = EXC_NONE;
        mem_mem_type = MEM_NOP; mem_mem_size = MEM_WORD;
        slot_v = 1'b0; slot_wait = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ld.w 0x1000 -> r5, response one cycle later
        step(0, 0, 1, 1, 0, mk(32'h1c00_0000, 32'h1000, 5'd5, MEM_LOAD, MEM_WORD, 32'hDEAD_BEEF, 0, EXC_NONE), acc);
        step(0, 1, 0, 0, 0, nop_i, acc);

        // byte/half alignment and extension
        step(0, 0, 1, 1, 0, mk(32'h1c00_0004, 32'h1003, 5'd7, MEM_LOAD, MEM_BYTE, 32'h8011_2233, 0, EXC_NONE), acc);
        step(0, 1, 0, 0, 0, nop_i, acc);
        step(0, 0, 1, 1, 0, mk(32'h1c00_0008, 32'h1003, 5'd7, MEM_LOADU, MEM_BYTE, 32'h8011_2233, 0, EXC_NONE), acc);
        step(0, 1, 0, 0, 0, nop_i, acc);
        step(0, 0, 1, 1, 0, mk(32'h1c00_000c, 32'h1002, 5'd7, MEM_LOAD, MEM_HALF, 32'h8011_2233, 0, EXC_NONE), acc);
        step(0, 1, 0, 0, 0, nop_i, acc);

        // ALE to r3: retires next cycle with no response awaited
        step(0, 0, 1, 1, 0, mk(32'h1c00_0010, 32'h1001, 5'd3, MEM_LOAD, MEM_WORD, 32'h0, 1, EXC_ALE), acc);
        step(0, 0, 0, 0, 0, nop_i, acc);

        // store held three cycles; follower enters in the retire cycle
        step(0, 0, 1, 1, 0, mk(32'h1c00_0014, 32'h2000, 5'd0, MEM_STORE, MEM_WORD, 32'h0, 0, EXC_NONE), acc);
        cur = mk(32'h1c00_0018, 32'h1234_5678, 5'd9, MEM_NOP, MEM_WORD, 32'h0, 0, EXC_NONE);
        repeat (3) step(0, 0, 1, 1, 0, cur, acc);
        step(0, 1, 1, 1, 0, cur, acc);
        step(0, 0, 0, 0, 0, nop_i, acc);

        // flush while waiting plus a fired MEM request: two stale responses
        step(0, 0, 1, 1, 0, mk(32'h1c00_0020, 32'h3000, 5'd10, MEM_LOAD, MEM_WORD, 32'h1111_1111, 0, EXC_NONE), acc);
        step(1, 0, 1, 1, 1, mk(32'h1c00_0024, 32'h3004, 5'd11, MEM_LOAD, MEM_WORD, 32'h2222_2222, 0, EXC_NONE), acc);
        step(0, 1, 0, 0, 0, nop_i, acc);
        step(0, 0, 1, 1, 0, mk(32'h1c00_0028, 32'h3008, 5'd12, MEM_LOAD, MEM_WORD, 32'h3333_3333, 0, EXC_NONE), acc);
        step(0, 1, 0, 0, 0, nop_i, acc);
        step(0, 1, 0, 0, 0, nop_i, acc);
        step(0, 1, 0, 0, 0, nop_i, acc);  // response with nothing outstanding is ignored

        have_cur = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit fl, dok, mv, mr, sf;
            fl  = ($urandom_range(0, 19) == 0) && (stale_count() <= 1);
            dok = (outq.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
            if (!have_cur && $urandom_range(0, 9) < 7) begin
                cur      = rand_instr();
                have_cur = 1'b1;
            end
            mv = have_cur;
            mr = ($urandom_range(0, 7) != 0);
            sf = fl && mv && (cur.mt != MEM_NOP) && !cur.exc && ($urandom_range(0, 1) == 1);
            step(fl, dok, mv, mr, sf, have_cur ? cur : nop_i, acc);
            if (acc || (fl && mv)) have_cur = 1'b0;
        end

        for (int n = 0; n < 50 && (outq.size() > 0 || slot_v); n++)
            step(0, 1, 0, 0, 0, nop_i, acc);
        chk("drain_budget", 32'(outq.size()) + 32'(slot_v), 32'd0);

        // reset while waiting drops the load
        step(0, 0, 1, 1, 0, mk(32'h1c00_0040, 32'h4000, 5'd13, MEM_LOAD, MEM_WORD, 32'h4444_4444, 0, EXC_NONE), acc);
        step(0, 0, 0, 0, 0, nop_i, acc);
        reset  = 1'b0;
        slot_v = 1'b0;
        outq.delete();
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");
        @(posedge clk);
        #1;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter DISCARD_W, 2, width of the stale-response discard counter; at most 2**DISCARD_W-1 responses are tracked.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  pipeline flush from exception/ertn commit.
REQ-005 mem_valid, mem_ready  in  1 each  MEM stage holds a valid instruction / its request is accepted or needs none.
REQ-006 mem_req_fire  in  1  MEM request accepted this cycle (mmu_valid && mmu_addr_ok).
REQ-007 mem_pc, mem_result  in  32 each  PC; ALU result or memory address.
REQ-008 mem_have_exception, mem_exception_type  in  1, exception_t  exception from MEM or earlier.
REQ-009 mem_dest  in  5; mem_mem_type  in  mem_type_t; mem_mem_size  in  mem_size_t.
REQ-010 wb_allowin  out  1  WB accepts a new instruction this cycle (drives MEM allowout).
REQ-011 data_ok  in  1; rdata  in  32  memory response, one per accepted request, in order.
REQ-012 rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  register-file write port.
REQ-013 wb_valid  out  1; wb_pc  out  32; wb_forwardable  out  1; wb_fwd_data  out  32.
REQ-014 wb_have_exception  out  1; wb_exception_type  out  exception_t; wb_badv  out  32  commit-time exception report.

Function
REQ-015 Stage registers WB_valid, WB_pc, WB_have_exception, WB_exception_type, WB_result, WB_dest, WB_mem_type, WB_mem_size, WB_wait SHALL load when mem_valid && mem_ready && wb_allowin && !flush.
REQ-016 WB_wait SHALL be set on load iff mem_mem_type != MEM_NOP && !mem_have_exception, cleared when a data_ok is consumed.
REQ-017 wb_ready = WB_valid && (!WB_wait || (data_ok && discard_cnt == 0)); wb_allowin = !WB_valid || wb_ready.
REQ-018 WB_valid SHALL clear when wb_ready and no new instruction is loaded, and on flush.
REQ-019 States: IDLE (!WB_valid), WAIT (WB_valid && WB_wait), DONE (WB_valid && !WB_wait); DONE and WAIT-with-consumed-data_ok retire in that cycle.
REQ-020 Load alignment: byte selects rdata[8*a+7:8*a] with a = WB_result[1:0]; half selects rdata[16*a1+15:16*a1] with a1 = WB_result[1]; word passes rdata.
REQ-021 MEM_LOAD sign-extends, MEM_LOADU zero-extends to 32 bits; MEM_STORE writes no register.
REQ-022 rf_we = wb_ready && !WB_have_exception && WB_dest != 0 && WB_mem_type != MEM_STORE; rf_wdata = aligned load data for loads, else WB_result.
REQ-023 wb_valid = wb_ready; wb_have_exception = wb_ready && WB_have_exception; wb_badv = WB_result.
REQ-024 wb_forwardable = WB_valid && !WB_have_exception && (WB_mem_type == MEM_NOP || (WB_wait && data_ok && discard_cnt == 0)); wb_fwd_data = rf_wdata.
REQ-025 On flush, discard_cnt SHALL increase by (WB_valid && WB_wait && !(data_ok && discard_cnt == 0)) + mem_req_fire.
REQ-026 Without flush, data_ok with discard_cnt != 0 SHALL decrement discard_cnt and never reach rf or WB state; flush and decrement in one cycle net together.
REQ-027 discard_cnt SHALL saturate at its maximum; overflow is a protocol error flagged by an assertion.
REQ-028 A data_ok arriving when !WB_wait and discard_cnt == 0 is a protocol error and SHALL be ignored.

Reset
REQ-029 Reset asserted: WB_valid = 0, WB_wait = 0, discard_cnt = 0, hence rf_we = 0, wb_valid = 0, wb_have_exception = 0, wb_allowin = 1; datapath registers unreset.
REQ-030 Reset mid-WAIT SHALL drop the instruction; responses after reset release are outside this block's contract.

Structure
REQ-031 exception_t, mem_type_t (extended with MEM_LOADU), mem_size_t SHALL live in the shared definitions package.
REQ-032 One sub-module load_align (rdata, addr[1:0], size, unsigned -> 32-bit data) is natural; remainder is flat.

Verification
REQ-033 ld.w at 0x1000 to r5, data_ok one cycle later with rdata 0xDEADBEEF -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF that cycle.
REQ-034 ld.b addr 0x1003, rdata 0x80112233 -> rf_wdata 0xFFFFFF80; ld.bu same -> 0x00000080; ld.h addr 0x1002 -> 0xFFFF8011.
REQ-035 Load in WAIT plus mem_req_fire, flush same cycle -> discard_cnt=2; next two data_ok consumed silently; third data_ok retires new load.
REQ-036 MEM instruction with ALE, dest r3 -> wb_have_exception=1, type ALE, wb_badv=mem_result, rf_we=0, no data_ok awaited.
REQ-037 Store to r0-space held 3 cycles in WAIT -> wb_allowin=0 throughout, retires with rf_we=0 on data_ok.
REQ-038 Reset asserted mid-WAIT then released -> all outputs at reset values, wb_allowin=1.
